axi_lite_regfile_slave: RTL
===========================

AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; only 32 or 64 is legal.
REQ-003 SHALL have parameter NUM_REGS, default 16, meaning register count; legal range is 1..2^(ADDR_WIDTH-ADDR_LSB).
REQ-004 SHALL have parameter RO_MASK, default 0, meaning NUM_REGS-bit mask; bit i=1 makes register i read-only.
REQ-005 SHALL have port clk, input, 1 bit, meaning clock; all logic is sampled on the rising edge.
REQ-006 SHALL have port resetn, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have ports AWADDR/AWVALID/AWREADY: input ADDR_WIDTH, input 1, output 1.
REQ-008 SHALL have ports WDATA/WSTRB/WVALID/WREADY: input DATA_WIDTH, input DATA_WIDTH/8, input 1, output 1.
REQ-009 SHALL have ports BRESP/BVALID/BREADY: output 2, output 1, input 1.
REQ-010 SHALL have ports ARADDR/ARVALID/ARREADY: input ADDR_WIDTH, input 1, output 1.
REQ-011 SHALL have ports RDATA/RRESP/RVALID/RREADY: output DATA_WIDTH, output 2, output 1, input 1.
REQ-012 SHALL have port reg_q, output, NUM_REGS*DATA_WIDTH, meaning current register contents; register i occupies slice i.
REQ-013 SHALL have port ro_in, input, NUM_REGS*DATA_WIDTH, meaning hardware-supplied values for read-only registers.
REQ-014 SHALL have port wr_pulse, output, NUM_REGS bits, meaning one-cycle strobe per successful register write.

Function
REQ-015 Register index SHALL be addr[ADDR_WIDTH-1:ADDR_LSB], where ADDR_LSB=log2(DATA_WIDTH/8); the low address bits SHALL be ignored.
REQ-016 AWREADY SHALL equal !aw_held and WREADY SHALL equal !w_held; both SHALL be driven from registers only, with no VALID-to-READY combinational path.
REQ-017 AW and W SHALL be accepted independently and in either order; a handshake on an edge SHALL capture the address or the data+strobe and set the matching held flag.
REQ-018 Commit SHALL occur on the edge where aw_held && w_held && !BVALID; the commit SHALL clear both held flags and set BVALID=1.
REQ-019 BVALID SHALL therefore rise two cycles after the later of the AW and W handshakes.
REQ-020 On commit to an index < NUM_REGS with RO_MASK bit clear, each byte b with WSTRB[b]=1 SHALL be written and other bytes kept; BRESP SHALL be OKAY (2'b00) and wr_pulse[index] SHALL be 1 for exactly one cycle.
REQ-021 On commit to an index >= NUM_REGS, or to a read-only index, no register SHALL change, BRESP SHALL be SLVERR (2'b10), and wr_pulse SHALL stay 0.
REQ-022 WSTRB=0 to a valid writable index SHALL give BRESP OKAY with no data change, and wr_pulse SHALL still pulse.
REQ-023 BVALID, BRESP, RVALID, RDATA and RRESP SHALL remain stable until their handshake completes, then drop on the next edge unless reloaded.
REQ-024 A new AW/W pair SHALL be acceptable while BVALID is pending; its commit SHALL wait until the B handshake completes.
REQ-025 ARREADY SHALL equal !RVALID.
REQ-026 An AR handshake SHALL set RVALID=1 on the same edge with RDATA captured, so read latency is one cycle.
REQ-027 RDATA SHALL be reg i for a writable register, ro_in slice i for a read-only register, and 0 with RRESP SLVERR for an out-of-range index.
REQ-028 When an AR capture and a commit to the same index occur on one edge, RDATA SHALL return the pre-write value.
REQ-029 Read and write paths SHALL operate concurrently; neither path SHALL stall the other.

Reset
REQ-030 resetn=0 SHALL asynchronously clear all registers, held flags, AWREADY/WREADY/ARREADY internal state, BVALID, RVALID, BRESP, RRESP, RDATA and wr_pulse to 0.
REQ-031 Deassertion of reset SHALL leave AWREADY=WREADY=ARREADY=1 on the first cycle.
REQ-032 Reset mid-transaction SHALL drop any held or pending transfer without a write and without a response.

Structure
REQ-033 Package axi_lite_pkg SHALL hold the resp_t enum (OKAY=2'b00, SLVERR=2'b10) and the constant function computing ADDR_LSB.
REQ-034 Sub-module axi_lite_strb_merge SHALL perform the combinational byte-enable merge of old data, new data and strobe.

Verification (DATA_WIDTH=32, NUM_REGS=8, RO_MASK=8'h80)
REQ-035 Write 0x04/0xDEADBEEF with WSTRB 4'hF -> BRESP OKAY, reg1=0xDEADBEEF, and wr_pulse[1] high for one cycle; a read of 0x04 returns 0xDEADBEEF one cycle after AR.
REQ-036 W presented 3 cycles before AW -> a single commit occurs and BVALID rises 2 cycles after the AW handshake.
REQ-037 Write 0x08/0x11223344 with WSTRB 4'b0101 over initial 0 -> reg2=0x00220044.
REQ-038 Write to 0x1C (RO) and to 0x20 (out of range) -> BRESP SLVERR and no change; a read of 0x1C returns ro_in[7]; a read of 0x20 returns 0 with SLVERR.
REQ-039 BREADY held low 10 cycles with a second AW/W issued -> the second AW/W is accepted and held, commits only after the B handshake, and BVALID/BRESP stay stable throughout.
REQ-040 resetn pulsed low between the AW and W handshakes -> all outputs return to 0, no register changes, and no BVALID follows.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// AXI-Lite register file shared types: response codes and
// the byte-lane address offset helper.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-enable merge: each lane takes new_data when its strb bit
// is set, else keeps old_data. Ports: old_data, new_data, strb, merged.
module axi_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite slave over NUM_REGS registers (RO_MASK picks ro_in-backed ones).
// Ports: AW/W/B/AR/R channels, reg_q contents, ro_in, wr_pulse strobes.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int SW       = DATA_WIDTH / 8;

  typedef logic [IDX_W-1:0] idx_t;

  logic                  aw_held;
  logic                  w_held;
  idx_t                  aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]         w_strb;
  logic                  bvalid;
  resp_t                 bresp;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;
  logic                  commit;
  logic [NUM_REGS-1:0]   wr_hit;
  idx_t                  ar_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  resp_t                 rd_resp;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AWADDR[ADDR_LSB-1:0],
                              ARADDR[ADDR_LSB-1:0]};

  assign AWREADY = !aw_held;
  assign WREADY  = !w_held;
  assign ARREADY = !rvalid;
  assign BVALID  = bvalid;
  assign BRESP   = bresp;
  assign RVALID  = rvalid;
  assign RDATA   = rdata;
  assign RRESP   = rresp;

  // Commit waits for the previous B response to drain.
  assign commit = aw_held && w_held && !bvalid;
  assign ar_idx = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] merged;

    assign wr_hit[i] = commit && (aw_idx == idx_t'(i))
                       && !RO_MASK[i];

    axi_lite_strb_merge #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
      .old_data(q),
      .new_data(w_data),
      .strb    (w_strb),
      .merged  (merged)
    );

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        q <= '0;
      else if (wr_hit[i]) q <= merged;
    end

    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q;
  end

  // Reads see reg_q before any same-edge commit lands.
  always_comb begin
    rd_data = '0;
    rd_resp = SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == idx_t'(i)) begin
        rd_resp = OKAY;
        rd_data = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH]
                             : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= wr_hit;
      if (AWVALID && !aw_held) begin
        aw_held <= 1'b1;
        aw_idx  <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (WVALID && !w_held) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (|wr_hit) ? OKAY : SLVERR;
      end else if (bvalid && BREADY) begin
        bvalid <= 1'b0;
        bresp  <= OKAY;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (!rvalid && ARVALID) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_resp;
    end else if (rvalid && RREADY) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end
  end

endmodule
